alu_seq_ctrl: RTL and testbench

Command-driven sequencer that owns the shared ALU and runs multi-element reductions on it: dot-product (`EXE_MAC`), running sum (`EXE_ADD`) or running max (`EXE_MP`) over a stream of operand pairs. It feeds the running result back into ALU port S2 and returns one final word per command. It sits between the layer controller (commands), the operand buffer (operand stream) and the ALU instance.

---
 rtl/alu_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - ALU reduction sequencer (MAC/ADD/MP) feeding acc back on S2.
// Optional cmd_bias port and MAC/ADD bias init under macro ALU_SEQ_BIAS_EN.

`ifndef WORD_BITS
`define WORD_BITS 16
`endif
`ifndef ALU_CFG_BITS
`define ALU_CFG_BITS 4
`endif
`ifndef EXE_NOP
`define EXE_NOP 0
`endif
`ifndef EXE_ADD
`define EXE_ADD 1
`endif
`ifndef EXE_MAC
`define EXE_MAC 2
`endif
`ifndef EXE_MP
`define EXE_MP 3
`endif

module alu_seq_ctrl #(
    parameter int WORD_BITS = `WORD_BITS,
    parameter int CFG_BITS  = `ALU_CFG_BITS,
    parameter int LEN_BITS  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CFG_BITS-1:0]  cmd_op,
    input  logic [LEN_BITS-1:0]  cmd_len,
`ifdef ALU_SEQ_BIAS_EN
    input  logic [WORD_BITS-1:0] cmd_bias,
`endif
    input  logic                 opd_valid,
    output logic                 opd_ready,
    input  logic [WORD_BITS-1:0] opd_a,
    input  logic [WORD_BITS-1:0] opd_b,
    output logic                 alu_en,
    output logic [CFG_BITS-1:0]  alu_cfg,
    output logic                 alu_s0_valid,
    output logic                 alu_s1_valid,
    output logic                 alu_s2_valid,
    output logic [WORD_BITS-1:0] alu_s0,
    output logic [WORD_BITS-1:0] alu_s1,
    output logic [WORD_BITS-1:0] alu_s2,
    input  logic [WORD_BITS-1:0] alu_d0,
    input  logic                 alu_valid,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WORD_BITS-1:0] res_data,
    output logic                 busy,
    output logic                 alu_err
);

    localparam logic [CFG_BITS-1:0] OP_NOP = CFG_BITS'(`EXE_NOP);
    localparam logic [CFG_BITS-1:0] OP_ADD = CFG_BITS'(`EXE_ADD);
    localparam logic [CFG_BITS-1:0] OP_MAC = CFG_BITS'(`EXE_MAC);
    localparam logic [CFG_BITS-1:0] OP_MP  = CFG_BITS'(`EXE_MP);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t               r_state;
    logic [CFG_BITS-1:0]  r_alu_cfg;
    logic                 r_svalid;
    logic [WORD_BITS-1:0] r_a;
    logic [WORD_BITS-1:0] r_b;
    logic [WORD_BITS-1:0] r_acc;
    logic [LEN_BITS-1:0]  r_len;
    logic [LEN_BITS-1:0]  r_count;
    logic                 r_alu_err;

    logic [CFG_BITS-1:0]  w_op;
    logic [WORD_BITS-1:0] w_init;
    logic                 w_last;

    // Unknown op codes collapse to NOP so they never reach the ALU.
    always_comb begin
        w_op = OP_NOP;
        if (cmd_op == OP_MAC || cmd_op == OP_ADD || cmd_op == OP_MP)
            w_op = cmd_op;
        w_init = '0;
        if (w_op == OP_MP)
            w_init = {1'b1, {(WORD_BITS-1){1'b0}}};
`ifdef ALU_SEQ_BIAS_EN
        else if (w_op != OP_NOP)
            w_init = cmd_bias;
`endif
    end

    assign w_last = (r_count + LEN_BITS'(1)) == r_len;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_alu_cfg <= OP_NOP;
            r_svalid  <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_len     <= '0;
            r_count   <= '0;
            r_alu_err <= 1'b0;
        end else begin
            if (alu_valid && r_state != S_WAIT)
                r_alu_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_len   <= cmd_len;
                        r_acc   <= w_init;
                        r_count <= '0;
                        if (cmd_len == '0 || w_op == OP_NOP) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state   <= S_FETCH;
                            r_alu_cfg <= w_op;
                        end
                    end
                end
                S_FETCH: begin
                    if (opd_valid) begin
                        r_a      <= opd_a;
                        r_b      <= opd_b;
                        r_svalid <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_svalid <= 1'b0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_valid) begin
                        r_acc   <= alu_d0;
                        r_count <= r_count + LEN_BITS'(1);
                        if (w_last) begin
                            r_state   <= S_DONE;
                            r_alu_cfg <= OP_NOP;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready    = RST && (r_state == S_IDLE);
    assign opd_ready    = (r_state == S_FETCH);
    assign alu_en       = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign alu_cfg      = r_alu_cfg;
    assign alu_s0_valid = r_svalid;
    assign alu_s1_valid = r_svalid;
    assign alu_s2_valid = r_svalid;
    assign alu_s0       = r_a;
    assign alu_s1       = r_b;
    assign alu_s2       = r_acc;
    assign res_valid    = (r_state == S_DONE);
    assign res_data     = r_acc;
    assign busy         = (r_state != S_IDLE);
    assign alu_err      = r_alu_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl with a behavioural ALU.

`ifndef WORD_BITS
`define WORD_BITS 16
`endif
`ifndef ALU_CFG_BITS
`define ALU_CFG_BITS 4
`endif
`ifndef EXE_NOP
`define EXE_NOP 0
`endif
`ifndef EXE_ADD
`define EXE_ADD 1
`endif
`ifndef EXE_MAC
`define EXE_MAC 2
`endif
`ifndef EXE_MP
`define EXE_MP 3
`endif

module tb_alu_seq_ctrl;

    localparam logic [3:0] OP_NOP = 4'(`EXE_NOP);
    localparam logic [3:0] OP_ADD = 4'(`EXE_ADD);
    localparam logic [3:0] OP_MAC = 4'(`EXE_MAC);
    localparam logic [3:0] OP_MP  = 4'(`EXE_MP);
`ifdef ALU_SEQ_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [7:0]  cmd_len = '0;
    logic [15:0] cmd_bias = '0;
    logic        opd_valid = 1'b0, opd_ready;
    logic [15:0] opd_a = '0, opd_b = '0;
    logic        alu_en;
    logic [3:0]  alu_cfg;
    logic        alu_s0_valid, alu_s1_valid, alu_s2_valid;
    logic [15:0] alu_s0, alu_s1, alu_s2;
    logic [15:0] alu_d0 = '0;
    logic        alu_valid;
    logic        res_valid, res_ready = 1'b0;
    logic [15:0] res_data;
    logic        busy, alu_err;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    alu_seq_ctrl dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
`ifdef ALU_SEQ_BIAS_EN
        .cmd_bias(cmd_bias),
`endif
        .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_a(opd_a), .opd_b(opd_b),
        .alu_en(alu_en), .alu_cfg(alu_cfg),
        .alu_s0_valid(alu_s0_valid), .alu_s1_valid(alu_s1_valid), .alu_s2_valid(alu_s2_valid),
        .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2),
        .alu_d0(alu_d0), .alu_valid(alu_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .alu_err(alu_err)
    );

    // Q9.6 ALU semantics: MAC = s2 + s0*s1, ADD = s0+s1+s2, MP = max of the three.
    function automatic logic [15:0] alu_step(logic [3:0] op, logic [15:0] acc, logic [15:0] a, logic [15:0] b);
        int ia, ib, ic, m;
        ia = $signed(a); ib = $signed(b); ic = $signed(acc);
        case (op)
            OP_MAC: return 16'(ic + ((ia * ib) >>> 6));
            OP_ADD: return 16'(ic + ia + ib);
            OP_MP: begin
                m = ic;
                if (ia > m) m = ia;
                if (ib > m) m = ib;
                return 16'(m);
            end
            default: return acc;
        endcase
    endfunction

    int          alu_lat = 1;
    int          alu_pend = 0;
    logic        spur = 1'b0;
    int          issues = 0;
    int          en_cycles = 0;
    logic [15:0] s2_log [0:4095];

    always @(posedge CLK) begin
        if (!RST) begin
            alu_pend <= 0;
        end else if (alu_s0_valid && alu_s1_valid && alu_s2_valid) begin
            alu_pend <= alu_lat;
            alu_d0   <= alu_step(alu_cfg, alu_s2, alu_s0, alu_s1);
            s2_log[issues[11:0]] <= alu_s2;
            issues   <= issues + 1;
        end else if (alu_pend > 0) begin
            alu_pend <= alu_pend - 1;
        end
    end
    assign alu_valid = (alu_pend == 1) || spur;

    always @(negedge CLK) if (alu_en || opd_ready) en_cycles <= en_cycles + 1;

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    logic [15:0] pa [0:7];
    logic [15:0] pb [0:7];
    logic [15:0] exp_s2 [0:7];

    // Reference: fold the operand list from the init value, logging each S2 the ALU should see.
    function automatic logic [15:0] ref_fold(input logic [3:0] op, input int len, input logic [15:0] bias, output int n_iss);
        logic [3:0]  eff;
        logic [15:0] acc;
        eff = (op == OP_MAC || op == OP_ADD || op == OP_MP) ? op : OP_NOP;
        acc = (eff == OP_MP) ? 16'h8000 : ((eff != OP_NOP && BIAS_EN) ? bias : 16'h0000);
        n_iss = (eff == OP_NOP) ? 0 : len;
        for (int i = 0; i < n_iss; i++) begin
            exp_s2[i] = acc;
            acc = alu_step(eff, acc, pa[i], pb[i]);
        end
        return acc;
    endfunction

    task automatic run_cmd(input logic [3:0] op, input int len, input logic [15:0] bias,
                           input logic [15:0] exp, input int hold, input string nm);
        int i0, e0, idx, cyc, n_iss;
        logic [15:0] r, held;
        logic stable;
        void'(ref_fold(op, len, bias, n_iss));
        i0 = issues; idx = 0;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = 8'(len); cmd_bias = bias;
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin @(negedge CLK); cyc++; end
        chk(32'(cmd_ready), 32'd1, {nm, "_cmd_ready"});
        e0 = en_cycles;
        @(negedge CLK);
        cmd_valid = 1'b0;
        if (n_iss == 0) chk(32'(res_valid), 32'd1, {nm, "_lat1"});
        cyc = 0;
        while (!res_valid && cyc < 2000) begin
            if (opd_ready && idx < len && $urandom_range(0, 3) != 0) begin
                opd_valid = 1'b1; opd_a = pa[idx]; opd_b = pb[idx]; idx++;
            end else begin
                opd_valid = 1'b0;
            end
            @(negedge CLK); cyc++;
        end
        opd_valid = 1'b0;
        chk(32'(res_valid), 32'd1, {nm, "_res_valid"});
        r = res_data;
        chk(32'(r), 32'(exp), {nm, "_res_data"});
        chk(32'(issues - i0), 32'(n_iss), {nm, "_issues"});
        for (int i = 0; i < n_iss; i++)
            chk(32'(s2_log[(i0 + i) % 4096]), 32'(exp_s2[i]), {nm, "_s2"});
        if (n_iss == 0) chk(32'(en_cycles - e0), 32'd0, {nm, "_no_alu"});
        chk(32'({busy, cmd_ready}), 32'b10, {nm, "_busy"});
        stable = 1'b1; held = res_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            if (!res_valid || res_data !== held || cmd_ready) stable = 1'b0;
        end
        if (hold > 0) chk(32'(stable), 32'd1, {nm, "_hold"});
        res_ready = 1'b1;
        @(negedge CLK);
        res_ready = 1'b0;
        chk(32'({res_valid, busy, cmd_ready}), 32'b001, {nm, "_release"});
    endtask

    typedef struct {
        logic [3:0]  op;
        int          len;
        logic [15:0] a [4];
        logic [15:0] b [4];
        logic [15:0] exp;
        int          hold;
        string       nm;
    } vec_t;

    vec_t vecs [6];

    task automatic check_reset_outputs(input string nm);
        chk(32'({cmd_ready, opd_ready, alu_en, alu_s0_valid, alu_s1_valid, alu_s2_valid, res_valid, busy, alu_err}),
            32'd0, {nm, "_flags"});
        chk(32'(alu_cfg), 32'(OP_NOP), {nm, "_cfg"});
        chk({alu_s0, alu_s1}, 32'd0, {nm, "_s01"});
        chk({alu_s2, res_data}, 32'd0, {nm, "_s2_res"});
    endtask

    initial begin
        int i0, cyc, n;
        logic [3:0]  rop;
        logic [15:0] rb, rexp;

        vecs[0] = '{OP_MAC, 3, '{16'h0040, 16'h0020, 16'hFFA0, 16'h0}, '{16'h0080, 16'h0100, 16'h0080, 16'h0}, 16'h0040, 0, "mac3"};
        vecs[1] = '{OP_MP,  2, '{16'hF9A0, 16'hFF60, 16'h0, 16'h0}, '{16'hFB60, 16'hF880, 16'h0, 16'h0}, 16'hFF60, 0, "mp2"};
        vecs[2] = '{OP_ADD, 2, '{16'hFAE0, 16'h00A0, 16'h0, 16'h0}, '{16'hFAE0, 16'h0000, 16'h0, 16'h0}, 16'hF660, 5, "add2"};
        vecs[3] = '{OP_MAC, 0, '{16'h0040, 16'h0, 16'h0, 16'h0}, '{16'h0040, 16'h0, 16'h0, 16'h0}, 16'h0000, 0, "mac0"};
        vecs[4] = '{OP_NOP, 4, '{16'h0040, 16'h0, 16'h0, 16'h0}, '{16'h0040, 16'h0, 16'h0, 16'h0}, 16'h0000, 0, "nop4"};
        vecs[5] = '{OP_MP,  0, '{16'h0, 16'h0, 16'h0, 16'h0}, '{16'h0, 16'h0, 16'h0, 16'h0}, 16'h8000, 0, "mp0"};

        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b1;
        @(negedge CLK);
        chk(32'({cmd_ready, busy}), 32'b10, "idle_ready");

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 4; k++) begin pa[k] = vecs[v].a[k]; pb[k] = vecs[v].b[k]; end
            alu_lat = v + 1;
            i0 = issues;
            run_cmd(vecs[v].op, vecs[v].len, 16'h0000, vecs[v].exp, vecs[v].hold, vecs[v].nm);
            if (v == 0) chk({s2_log[i0], s2_log[i0+1]}, {16'h0000, 16'h0080}, "mac3_s2_const");
            if (v == 1) chk(32'(s2_log[i0]), 32'h8000, "mp2_s2_first");
        end

`ifdef ALU_SEQ_BIAS_EN
        pa[0] = 16'h0040; pb[0] = 16'h0040; alu_lat = 2;
        i0 = issues;
        run_cmd(OP_MAC, 1, 16'h0040, 16'h0080, 0, "bias_mac1");
        chk(32'(s2_log[i0]), 32'h0040, "bias_s2_first");
`endif

        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 4))
                0: rop = OP_MAC; 1: rop = OP_ADD; 2: rop = OP_MP; 3: rop = OP_NOP; default: rop = 4'hF;
            endcase
            n = $urandom_range(0, 6);
            for (int k = 0; k < 8; k++) begin
                pa[k] = 16'($urandom_range(0, 1023)) - 16'd512;
                pb[k] = 16'($urandom_range(0, 1023)) - 16'd512;
            end
            rb = 16'($urandom_range(0, 255)) - 16'd128;
            alu_lat = $urandom_range(1, 3);
            rexp = ref_fold(rop, n, rb, cyc);
            run_cmd(rop, n, rb, rexp, $urandom_range(0, 2), "rand");
        end

        // Abort a MAC in the WAIT of its second element.
        pa[0] = 16'h0040; pb[0] = 16'h0080; pa[1] = 16'h0020; pb[1] = 16'h0100; pa[2] = 16'h0040; pb[2] = 16'h0040;
        alu_lat = 3;
        i0 = issues;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = OP_MAC; cmd_len = 8'd3;
        @(negedge CLK);
        cmd_valid = 1'b0;
        n = 0; cyc = 0;
        while (!(issues == i0 + 2 && alu_en && !opd_ready && !alu_s0_valid) && cyc < 200) begin
            if (opd_ready && n < 3) begin opd_valid = 1'b1; opd_a = pa[n]; opd_b = pb[n]; n++; end
            else opd_valid = 1'b0;
            @(negedge CLK); cyc++;
        end
        opd_valid = 1'b0;
        chk(32'(issues - i0), 32'd2, "abort_reached_wait");
        RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("abort");
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        chk(32'({res_valid, busy, cmd_ready, alu_err}), 32'b0010, "abort_idle");

        spur = 1'b1;
        @(negedge CLK);
        spur = 1'b0;
        chk(32'(alu_err), 32'd1, "err_set");
        pa[0] = 16'h0040; pb[0] = 16'h0040; alu_lat = 1;
        run_cmd(OP_ADD, 1, 16'h0000, BIAS_EN ? 16'h0080 : 16'h0080, 0, "after_err");
        chk(32'(alu_err), 32'd1, "err_sticky");
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        chk(32'(alu_err), 32'd0, "err_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
